// File: rtl/config_stream_loader.sv
// Byte-stream configuration master: parses T/AH/AL/C/payload packets and issues one
// single-cycle tile loader write per payload byte. Optional trailing checksum: CFG_CHECKSUM_EN.
module config_stream_loader #(
  parameter int unsigned NB_TILES = 16,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 8
) (
  input  logic                conf,
  input  logic                reset,
  input  logic [7:0]          cfg_in_data,
  input  logic                cfg_in_valid,
  output logic                cfg_in_ready,
  output logic [NB_TILES-1:0] select_tile,
  output logic [ADDR_W-1:0]   address_tile,
  output logic [DATA_W-1:0]   data_tile,
  output logic                busy,
  output logic                done,
  output logic                err,
  input  logic                err_clr
);

  typedef enum logic [2:0] {
    StIdle,
    StAddrHi,
    StAddrLo,
    StCount,
    StPayload,
`ifdef CFG_CHECKSUM_EN
    StCheck,
`endif
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic                ready_q;
  logic [7:0]          tile_q, tile_d;
  logic                tile_ok_q, tile_ok_d;
  logic [7:0]          ah_q, ah_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [NB_TILES-1:0] sel_q, sel_d;
  logic [ADDR_W-1:0]   addr_out_q, addr_out_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                err_q, err_d, err_set;
  logic                accept;
`ifdef CFG_CHECKSUM_EN
  logic [7:0]          sum_q, sum_d;
`endif

  assign accept = cfg_in_valid & ready_q;

  always_comb begin
    state_d    = state_q;
    tile_d     = tile_q;
    tile_ok_d  = tile_ok_q;
    ah_d       = ah_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    sel_d      = '0;
    addr_out_d = addr_out_q;
    data_d     = data_q;
    err_set    = 1'b0;
`ifdef CFG_CHECKSUM_EN
    sum_d      = sum_q;
    if (accept) sum_d = sum_q + cfg_in_data;
`endif
    unique case (state_q)
      StIdle: if (accept) begin
        tile_d    = cfg_in_data;
        tile_ok_d = 32'(cfg_in_data) < NB_TILES;
        err_set   = ~tile_ok_d;
`ifdef CFG_CHECKSUM_EN
        sum_d     = cfg_in_data;
`endif
        state_d   = StAddrHi;
      end
      StAddrHi: if (accept) begin
        ah_d    = cfg_in_data;
        state_d = StAddrLo;
      end
      StAddrLo: if (accept) begin
        addr_d  = ADDR_W'({ah_q, cfg_in_data});
        state_d = StCount;
      end
      StCount: if (accept) begin
        cnt_d   = cfg_in_data;
        state_d = StPayload;
      end
      StPayload: if (accept) begin
        // Invalid tiles still consume payload but never raise a select.
        sel_d      = tile_ok_q ? (NB_TILES'(1) << tile_q) : '0;
        addr_out_d = addr_q;
        data_d     = DATA_W'(cfg_in_data);
        addr_d     = addr_q + ADDR_W'(1);
        cnt_d      = cnt_q - 8'd1;
        if (cnt_q == 8'd0) begin
`ifdef CFG_CHECKSUM_EN
          state_d = StCheck;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef CFG_CHECKSUM_EN
      StCheck: if (accept) begin
        err_set = cfg_in_data != sum_q;
        state_d = StDone;
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // A new error takes priority over a simultaneous clear.
    err_d = err_set | (err_q & ~err_clr);
  end

  always_ff @(posedge conf or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      ready_q    <= 1'b0;
      tile_q     <= '0;
      tile_ok_q  <= 1'b0;
      ah_q       <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      sel_q      <= '0;
      addr_out_q <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
`ifdef CFG_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ready_q    <= state_d != StDone;
      tile_q     <= tile_d;
      tile_ok_q  <= tile_ok_d;
      ah_q       <= ah_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      addr_out_q <= addr_out_d;
      data_q     <= data_d;
      err_q      <= err_d;
`ifdef CFG_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign cfg_in_ready = ready_q;
  assign select_tile  = sel_q;
  assign address_tile = addr_out_q;
  assign data_tile    = data_q;
  assign busy         = state_q != StIdle;
  assign done         = state_q == StDone;
  assign err          = err_q;

endmodule
